vc_input_buffer: RTL and testbench
==================================

# vc_input_buffer

Parametrised multi-virtual-channel input buffer for the wormhole router input port, one per input port. It stores incoming flits in one circular FIFO per virtual channel (VC) and raises per-VC on/off flow-control to the upstream router with programmable hysteresis thresholds. It reports per-VC occupancy and sticky overflow/underflow errors, and presents the head flit of the VC currently selected for reading to the route/switch-allocation stage.

## Interface
Parameters:
- FLIT_WIDTH, 64, flit width in bits
- DEPTH, 16, entries per VC; power of two, >= 4
- NUM_VC, 2, number of virtual channels, >= 1
- OFF_THRESH, DEPTH-2, occupancy at or above which vc_on drops; ON_THRESH < OFF_THRESH <= DEPTH
- ON_THRESH, 2, occupancy at or below which vc_on rises
- Derived: VC_W = max(1,$clog2(NUM_VC)), CNT_W = $clog2(DEPTH+1)

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- flit_in  in  FLIT_WIDTH  incoming flit
- push  in  1  write flit_in into VC push_vc
- push_vc  in  VC_W  target VC of write
- pop  in  1  remove head flit of VC pop_vc
- pop_vc  in  VC_W  VC selected for read/pop
- err_clr  in  1  clears sticky error flags
- flit_o  out  FLIT_WIDTH  head flit of VC pop_vc (first-word fall-through)
- full  out  NUM_VC  per-VC full (count == DEPTH)
- empty  out  NUM_VC  per-VC empty (count == 0)
- vc_on  out  NUM_VC  per-VC on/off credit to upstream; 1 = may send
- count  out  NUM_VC*CNT_W  per-VC occupancy, VC v at [v*CNT_W +: CNT_W]
- overflow_err  out  NUM_VC  sticky: push to full VC dropped
- underflow_err  out  NUM_VC  sticky: pop on empty VC ignored

## Operation
- Reset (rst=1 at a clk edge): all read/write pointers 0, count 0, empty all-1, full all-0, vc_on all-1, both error vectors 0. Storage array not reset; flit_o is don't-care while empty[pop_vc]=1. rst overrides push/pop in the same cycle; mid-operation reset discards all buffered flits.
- Per VC v: independent write pointer, read pointer, count; pointers DEPTH-wide modulo (wrap DEPTH-1 -> 0).
- Write accepted when push && (count[v] < DEPTH || pop accepted on same VC this cycle). Stores flit_in at wr_ptr[v], wr_ptr increments.
- Push to full VC without same-VC pop: flit dropped, no state change except overflow_err[v] <= 1.
- Pop accepted when pop && count[pop_vc] > 0; rd_ptr increments. Pop on empty VC: ignored, underflow_err <= 1, even if same-VC push in same cycle (push still stored; no bypass).
- Same-VC push+pop both accepted: count unchanged, both pointers advance. Different-VC push+pop: each VC updated independently.
- count_next = count + write_acc - pop_acc (per VC, CNT_W bits, never wraps).
- vc_on[v] next: 0 if count_next >= OFF_THRESH; 1 if count_next <= ON_THRESH; else hold (hysteresis).
- err_clr clears both error vectors; an error event in the same cycle wins (flag stays 1).
- pop_vc/push_vc values >= NUM_VC: operation ignored, no flags.

## Timing
- full, empty, count, vc_on, error flags all registered; update on the edge that accepts the push/pop.
- flit_o combinational from storage at rd_ptr[pop_vc]; write-to-read latency 1 cycle (flit pushed at edge N is visible at flit_o after edge N when VC was empty).
- Pop-to-next-head: new head visible immediately after popping edge.
- Sustained throughput 1 push + 1 pop per cycle, including at full (same VC).
- No combinational path from push/flit_in to any output.

## Test plan
- Reset then push 16 flits 0x1..0x10 to VC0 (DEPTH=16) -> full[0]=1 after 16th edge, count[0]=16, vc_on[0]=0 after 14th push; VC1 empty/vc_on=1 throughout.
- Pop VC0 16 times -> flit_o sequence 0x1..0x10, empty[0]=1 after last edge; vc_on[0] stays 0 until count=2, returns to 1 on that edge.
- VC0 full, push 0xAA with no pop -> dropped, overflow_err[0]=1, count 16; then push 0xBB + pop VC0 same cycle -> accepted, count 16, 0xBB emerges as 16th subsequent pop.
- VC1 empty, push 0x55 + pop VC1 same cycle -> underflow_err[1]=1, count[1]=1, flit_o=0x55 next cycle; err_clr -> flags 0.
- Interleave push VC0 / pop VC1 every cycle for 100 cycles across pointer wrap -> per-VC FIFO order preserved, counts match scoreboard.
- Assert rst with both VCs half full -> next cycle all counts 0, empty all-1, vc_on all-1, flags 0.

Source files
------------

// File: rtl/vc_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vc_input_buffer
// Purpose  : Multi-virtual-channel input buffer for a wormhole router port.
//            One circular FIFO per VC, per-VC on/off flow control with
//            hysteresis, occupancy counts and sticky over/underflow flags.
//            The head flit of VC pop_vc is presented first-word fall-through.
// Ports    : clk, rst (sync, active-high)
//            flit_in/push/push_vc : write side
//            pop/pop_vc           : read side; flit_o = head of pop_vc
//            err_clr              : clears sticky error flags
//            full/empty/vc_on/count/overflow_err/underflow_err : per-VC status
// Revision : 1.0 - initial release
// ============================================================================
module vc_input_buffer #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int NUM_VC     = 2,
    parameter int OFF_THRESH = DEPTH - 2,
    parameter int ON_THRESH  = 2,
    localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLIT_WIDTH-1:0]   flit_in,
    input  logic                    push,
    input  logic [VC_W-1:0]         push_vc,
    input  logic                    pop,
    input  logic [VC_W-1:0]         pop_vc,
    input  logic                    err_clr,
    output logic [FLIT_WIDTH-1:0]   flit_o,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       vc_on,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic [NUM_VC-1:0]       overflow_err,
    output logic [NUM_VC-1:0]       underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_OFF   = CNT_W'(OFF_THRESH);
    localparam logic [CNT_W-1:0] C_ON    = CNT_W'(ON_THRESH);

    logic [FLIT_WIDTH-1:0] w_head [NUM_VC];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]      r_wr_ptr;
        logic [PTR_W-1:0]      r_rd_ptr;
        logic [CNT_W-1:0]      r_count;
        logic                  r_full;
        logic                  r_empty;
        logic                  r_vc_on;
        logic                  r_ovf;
        logic                  r_unf;

        logic                  w_push_sel;
        logic                  w_pop_sel;
        logic                  w_pop_acc;
        logic                  w_push_acc;
        logic                  w_ovf_evt;
        logic                  w_unf_evt;
        logic [CNT_W-1:0]      w_count_next;

        // Out-of-range VC selects match no generate instance and are ignored.
        assign w_push_sel = push && (push_vc == VC_W'(v));
        assign w_pop_sel  = pop  && (pop_vc  == VC_W'(v));
        assign w_pop_acc  = w_pop_sel && (r_count != '0);
        // A pop in the same cycle frees a slot, so a full VC still accepts.
        assign w_push_acc = w_push_sel && ((r_count != C_DEPTH) || w_pop_acc);
        assign w_ovf_evt  = w_push_sel && !w_push_acc;
        assign w_unf_evt  = w_pop_sel && !w_pop_acc;

        assign w_count_next = r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_acc);

        // Storage is intentionally not reset.
        always_ff @(posedge clk) begin
            if (w_push_acc) begin
                r_mem[r_wr_ptr] <= flit_in;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_full   <= 1'b0;
                r_empty  <= 1'b1;
                r_vc_on  <= 1'b1;
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
            end else begin
                if (w_push_acc) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop_acc) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= w_count_next;
                r_full  <= (w_count_next == C_DEPTH);
                r_empty <= (w_count_next == '0);
                // Hysteresis: between the thresholds the previous state holds.
                if (w_count_next >= C_OFF) begin
                    r_vc_on <= 1'b0;
                end else if (w_count_next <= C_ON) begin
                    r_vc_on <= 1'b1;
                end
                // A new error event wins over a simultaneous clear.
                if (w_ovf_evt) begin
                    r_ovf <= 1'b1;
                end else if (err_clr) begin
                    r_ovf <= 1'b0;
                end
                if (w_unf_evt) begin
                    r_unf <= 1'b1;
                end else if (err_clr) begin
                    r_unf <= 1'b0;
                end
            end
        end

        assign w_head[v]                  = r_mem[r_rd_ptr];
        assign count[v*CNT_W +: CNT_W]    = r_count;
        assign full[v]                    = r_full;
        assign empty[v]                   = r_empty;
        assign vc_on[v]                   = r_vc_on;
        assign overflow_err[v]            = r_ovf;
        assign underflow_err[v]           = r_unf;
    end

    always_comb begin
        flit_o = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (pop_vc == VC_W'(v)) begin
                flit_o = w_head[v];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vc_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_input_buffer
// Purpose  : Self-checking bench for vc_input_buffer with directed and
//            randomized stimulus against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_input_buffer;

    localparam int FW    = 64;
    localparam int DEPTH = 16;
    localparam int NVC   = 2;
    localparam int OFF   = DEPTH - 2;
    localparam int ON    = 2;
    localparam int CNT_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [FW-1:0]   flit_in;
    logic            push;
    logic [0:0]      push_vc;
    logic            pop;
    logic [0:0]      pop_vc;
    logic            err_clr;
    logic [FW-1:0]   flit_o;
    logic [NVC-1:0]  full;
    logic [NVC-1:0]  empty;
    logic [NVC-1:0]  vc_on;
    logic [NVC*CNT_W-1:0] count;
    logic [NVC-1:0]  overflow_err;
    logic [NVC-1:0]  underflow_err;

    vc_input_buffer #(
        .FLIT_WIDTH (FW),
        .DEPTH      (DEPTH),
        .NUM_VC     (NVC),
        .OFF_THRESH (OFF),
        .ON_THRESH  (ON)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .flit_in       (flit_in),
        .push          (push),
        .push_vc       (push_vc),
        .pop           (pop),
        .pop_vc        (pop_vc),
        .err_clr       (err_clr),
        .flit_o        (flit_o),
        .full          (full),
        .empty         (empty),
        .vc_on         (vc_on),
        .count         (count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per VC plus flag bits.
    logic [FW-1:0] q [NVC][$];
    logic [NVC-1:0] m_ovf, m_unf, m_on;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle from the negedge, check flit_o before the edge and all
    // registered status after it.
    task automatic cycle(input logic p, input logic pv, input logic [FW-1:0] d,
                         input logic po, input logic pov, input logic ec, input logic r);
        int  sz;
        bit  pop_ok, push_ok;
        rst = r; push = p; push_vc = pv; flit_in = d; pop = po; pop_vc = pov; err_clr = ec;
        #1;
        if (q[pov].size() > 0) check("flit_o", flit_o, q[pov][0]);
        if (r) begin
            for (int v = 0; v < NVC; v++) q[v].delete();
            m_ovf = '0; m_unf = '0; m_on = '1;
        end else begin
            pop_ok  = po && (q[pov].size() > 0);
            push_ok = p && ((q[pv].size() < DEPTH) || (pop_ok && pov == pv));
            if (ec) begin m_ovf = '0; m_unf = '0; end
            if (po && !pop_ok) m_unf[pov] = 1'b1;
            if (p && !push_ok) m_ovf[pv]  = 1'b1;
            if (pop_ok)  void'(q[pov].pop_front());
            if (push_ok) q[pv].push_back(d);
            for (int v = 0; v < NVC; v++) begin
                sz = q[v].size();
                if (sz >= OFF) m_on[v] = 1'b0;
                else if (sz <= ON) m_on[v] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int v = 0; v < NVC; v++) begin
            sz = q[v].size();
            check($sformatf("count%0d", v), FW'(count[v*CNT_W +: CNT_W]), FW'(sz));
            check($sformatf("full%0d", v),  FW'(full[v]),  FW'(sz == DEPTH));
            check($sformatf("empty%0d", v), FW'(empty[v]), FW'(sz == 0));
            check($sformatf("vc_on%0d", v), FW'(vc_on[v]), FW'(m_on[v]));
            check($sformatf("ovf%0d", v),   FW'(overflow_err[v]),  FW'(m_ovf[v]));
            check($sformatf("unf%0d", v),   FW'(underflow_err[v]), FW'(m_unf[v]));
        end
        @(negedge clk);
    endtask

    initial begin
        int ppct, opct;
        rst = 1'b1; push = 1'b0; push_vc = '0; pop = 1'b0; pop_vc = '0;
        flit_in = '0; err_clr = 1'b0;
        m_ovf = '0; m_unf = '0; m_on = '1;
        @(negedge clk);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Fill VC0 with 1..16, overflow, then push+pop at full.
        for (int i = 1; i <= DEPTH; i++) cycle(1, 0, FW'(i), 0, 0, 0, 0);
        cycle(1, 0, 64'hAA, 0, 0, 0, 0);
        cycle(1, 0, 64'hBB, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1, 0, 0, 0);
        // Underflow with simultaneous push, then clear.
        cycle(1, 1, 64'h55, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 0);
        // Clear collides with a new underflow event: event wins.
        cycle(0, 0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // Push VC0 / pop VC1 interleave across wrap.
        for (int i = 0; i < 100; i++) cycle(1, 0, {$urandom, $urandom}, 1, 1, 0, 0);

        // Half-fill both VCs then reset.
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, {$urandom, $urandom}, 0, 0, 0, 0);
            cycle(1, 1, {$urandom, $urandom}, 0, 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Randomized phases alternating fill-heavy and drain-heavy traffic.
        for (int k = 0; k < 16; k++) begin
            ppct = (k % 2 == 0) ? 85 : 30;
            opct = (k % 2 == 0) ? 30 : 85;
            for (int i = 0; i < 150; i++) begin
                cycle(($urandom_range(99) < ppct), 1'($urandom_range(1)), {$urandom, $urandom},
                      ($urandom_range(99) < opct), 1'($urandom_range(1)),
                      ($urandom_range(19) == 0), ($urandom_range(299) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
